// File: rtl/parking_gate_controller.sv
// Parking lot occupancy tracker and barrier sequencer: lowest-free-spot allocation, exit-first arbitration.
// All outputs registered (1-cycle grant latency); requests seen during an open window wait until IDLE.
module parking_gate_controller #(
  parameter  int NUM_SPOTS        = 8,
  parameter  int GATE_OPEN_CYCLES = 4,
  localparam int SPOT_W           = $clog2(NUM_SPOTS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                entry_req,
  input  logic                exit_req,
  input  logic [SPOT_W-1:0]   exit_spot,
  output logic                gate_open,
  output logic                entry_grant,
  output logic                exit_grant,
  output logic [SPOT_W-1:0]   assigned_spot,
  output logic [NUM_SPOTS-1:0] occupancy,
  output logic [SPOT_W:0]     free_count,
  output logic                full,
  output logic                exit_error
);

  localparam int                CNT_W       = $clog2(GATE_OPEN_CYCLES + 1);
  localparam logic [SPOT_W:0]   SPOTS_TOTAL = (SPOT_W + 1)'(NUM_SPOTS);
  localparam logic [CNT_W-1:0]  CNT_LOAD    = CNT_W'(GATE_OPEN_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    ENTRY_OPEN,
    EXIT_OPEN
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_SPOTS-1:0] occ_q, occ_d;
  logic [SPOT_W:0]      free_q, free_d;
  logic                 full_q, full_d;
  logic [SPOT_W-1:0]    spot_q, spot_d;
  logic                 gate_q, gate_d;
  logic                 entry_grant_q, entry_grant_d;
  logic                 exit_grant_q, exit_grant_d;
  logic                 exit_error_q, exit_error_d;

  logic                 exit_in_range;
  logic                 exit_ok;
  logic [SPOT_W-1:0]    free_spot;

  // Scan from the top so the last assignment wins with the lowest zero bit.
  function automatic logic [SPOT_W-1:0] lowest_free(input logic [NUM_SPOTS-1:0] occ);
    lowest_free = '0;
    for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
      if (!occ[i]) lowest_free = SPOT_W'(i);
    end
  endfunction

  always_comb begin
    exit_in_range = ({1'b0, exit_spot} < SPOTS_TOTAL);
    exit_ok       = exit_req && exit_in_range && occ_q[exit_spot];
    free_spot     = lowest_free(occ_q);

    state_d       = state_q;
    cnt_d         = cnt_q;
    occ_d         = occ_q;
    free_d        = free_q;
    full_d        = full_q;
    spot_d        = spot_q;
    gate_d        = gate_q;
    entry_grant_d = 1'b0;
    exit_grant_d  = 1'b0;
    exit_error_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (exit_ok) begin
          occ_d[exit_spot] = 1'b0;
          free_d           = free_q + (SPOT_W + 1)'(1);
          full_d           = 1'b0;
          exit_grant_d     = 1'b1;
          cnt_d            = CNT_LOAD;
          gate_d           = 1'b1;
          state_d          = EXIT_OPEN;
        end else begin
          // A bad exit must not starve a waiting entry in the same cycle.
          exit_error_d = exit_req;
          if (entry_req && !full_q) begin
            occ_d[free_spot] = 1'b1;
            free_d           = free_q - (SPOT_W + 1)'(1);
            full_d           = (free_q == (SPOT_W + 1)'(1));
            spot_d           = free_spot;
            entry_grant_d    = 1'b1;
            cnt_d            = CNT_LOAD;
            gate_d           = 1'b1;
            state_d          = ENTRY_OPEN;
          end
        end
      end
      ENTRY_OPEN, EXIT_OPEN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          gate_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        gate_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      occ_q         <= '0;
      free_q        <= SPOTS_TOTAL;
      full_q        <= 1'b0;
      spot_q        <= '0;
      gate_q        <= 1'b0;
      entry_grant_q <= 1'b0;
      exit_grant_q  <= 1'b0;
      exit_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      occ_q         <= occ_d;
      free_q        <= free_d;
      full_q        <= full_d;
      spot_q        <= spot_d;
      gate_q        <= gate_d;
      entry_grant_q <= entry_grant_d;
      exit_grant_q  <= exit_grant_d;
      exit_error_q  <= exit_error_d;
    end
  end

  assign gate_open     = gate_q;
  assign entry_grant   = entry_grant_q;
  assign exit_grant    = exit_grant_q;
  assign assigned_spot = spot_q;
  assign occupancy     = occ_q;
  assign free_count    = free_q;
  assign full          = full_q;
  assign exit_error    = exit_error_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller (8 spots, 4-cycle window); samples 1 time unit after each rising edge.
module tb_parking_gate_controller;

  localparam int NS = 8;
  localparam int G  = 4;
  localparam int SW = $clog2(NS);

  logic          clk;
  logic          rst_n;
  logic          entry_req;
  logic          exit_req;
  logic [SW-1:0] exit_spot;
  logic          gate_open;
  logic          entry_grant;
  logic          exit_grant;
  logic [SW-1:0] assigned_spot;
  logic [NS-1:0] occupancy;
  logic [SW:0]   free_count;
  logic          full;
  logic          exit_error;

  int checks = 0;
  int errors = 0;

  parking_gate_controller #(
    .NUM_SPOTS        (NS),
    .GATE_OPEN_CYCLES (G)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .entry_req     (entry_req),
    .exit_req      (exit_req),
    .exit_spot     (exit_spot),
    .gate_open     (gate_open),
    .entry_grant   (entry_grant),
    .exit_grant    (exit_grant),
    .assigned_spot (assigned_spot),
    .occupancy     (occupancy),
    .free_count    (free_count),
    .full          (full),
    .exit_error    (exit_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Grants an entry from IDLE, checks the grant cycle, then walks the whole window back to IDLE.
  task automatic do_entry(input int exp_spot, input logic [NS-1:0] exp_occ, input int exp_free);
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    chk("entry_grant", 64'(entry_grant), 64'd1);
    chk("assigned_spot", 64'(assigned_spot), 64'(exp_spot));
    chk("occ_after_entry", 64'(occupancy), 64'(exp_occ));
    chk("free_after_entry", 64'(free_count), 64'(exp_free));
    chk("gate_open_c1", 64'(gate_open), 64'd1);
    for (int i = 2; i <= G; i++) begin
      step();
      chk("gate_open_window", 64'(gate_open), 64'd1);
      chk("entry_grant_pulse", 64'(entry_grant), 64'd0);
    end
    step();
    chk("gate_closed", 64'(gate_open), 64'd0);
  endtask

  task automatic do_exit(input int spot, input logic [NS-1:0] exp_occ);
    exit_req  = 1'b1;
    exit_spot = SW'(spot);
    step();
    exit_req = 1'b0;
    chk("exit_grant", 64'(exit_grant), 64'd1);
    chk("occ_after_exit", 64'(occupancy), 64'(exp_occ));
    chk("gate_open_exit", 64'(gate_open), 64'd1);
    repeat (G) step();
    chk("gate_closed_exit", 64'(gate_open), 64'd0);
  endtask

  initial begin
    int grants;
    int opens;
    rst_n     = 1'b0;
    entry_req = 1'b0;
    exit_req  = 1'b0;
    exit_spot = '0;
    #12;
    chk("rst_gate", 64'(gate_open), 64'd0);
    chk("rst_egrant", 64'(entry_grant), 64'd0);
    chk("rst_xgrant", 64'(exit_grant), 64'd0);
    chk("rst_xerr", 64'(exit_error), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_free", 64'(free_count), 64'd8);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_spot", 64'(assigned_spot), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    do_entry(0, 8'h01, 7);
    for (int k = 1; k < NS; k++) do_entry(k, NS'((1 << (k + 1)) - 1), NS - 1 - k);
    chk("full_after_8", 64'(full), 64'd1);
    chk("free_after_8", 64'(free_count), 64'd0);

    // Ninth car waits at a full lot; request stays high into the exit test.
    entry_req = 1'b1;
    grants = 0;
    opens  = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      grants += int'(entry_grant);
      opens  += int'(gate_open);
    end
    chk("full_no_grant", 64'(grants), 64'd0);
    chk("full_gate_closed", 64'(opens), 64'd0);
    chk("full_occ_held", 64'(occupancy), 64'hFF);

    exit_req  = 1'b1;
    exit_spot = 3'd3;
    step();
    exit_req = 1'b0;
    chk("exit3_grant", 64'(exit_grant), 64'd1);
    chk("exit3_no_entry", 64'(entry_grant), 64'd0);
    chk("exit3_occ", 64'(occupancy), 64'hF7);
    chk("exit3_full", 64'(full), 64'd0);
    chk("exit3_free", 64'(free_count), 64'd1);
    repeat (G) step();
    chk("exit3_gate_closed", 64'(gate_open), 64'd0);
    chk("exit3_entry_waits", 64'(entry_grant), 64'd0);
    step();
    entry_req = 1'b0;
    chk("held_entry_grant", 64'(entry_grant), 64'd1);
    chk("held_entry_spot", 64'(assigned_spot), 64'd3);
    chk("held_entry_full", 64'(full), 64'd1);
    repeat (G) step();

    // Simultaneous requests: exit first, entry exactly G+1 cycles later.
    entry_req = 1'b1;
    exit_req  = 1'b1;
    exit_spot = 3'd0;
    step();
    exit_req = 1'b0;
    chk("sim_exit_first", 64'(exit_grant), 64'd1);
    chk("sim_entry_deferred", 64'(entry_grant), 64'd0);
    chk("sim_occ", 64'(occupancy), 64'hFE);
    grants = 0;
    for (int i = 0; i < G; i++) begin
      step();
      grants += int'(entry_grant);
    end
    chk("sim_no_early_entry", 64'(grants), 64'd0);
    step();
    entry_req = 1'b0;
    chk("sim_entry_grant", 64'(entry_grant), 64'd1);
    chk("sim_entry_spot", 64'(assigned_spot), 64'd0);
    chk("sim_occ_full", 64'(occupancy), 64'hFF);
    repeat (G) step();

    do_exit(5, 8'hDF);
    exit_req  = 1'b1;
    exit_spot = 3'd5;
    step();
    exit_req = 1'b0;
    chk("bad_exit_error", 64'(exit_error), 64'd1);
    chk("bad_exit_no_grant", 64'(exit_grant), 64'd0);
    chk("bad_exit_gate", 64'(gate_open), 64'd0);
    chk("bad_exit_occ", 64'(occupancy), 64'hDF);
    step();
    chk("bad_exit_pulse", 64'(exit_error), 64'd0);
    chk("bad_exit_gate2", 64'(gate_open), 64'd0);
    chk("bad_exit_free", 64'(free_count), 64'd1);

    // Invalid exit alongside an entry: error flagged and entry still served.
    exit_req  = 1'b1;
    exit_spot = 3'd5;
    entry_req = 1'b1;
    step();
    exit_req  = 1'b0;
    entry_req = 1'b0;
    chk("mix_error", 64'(exit_error), 64'd1);
    chk("mix_entry_grant", 64'(entry_grant), 64'd1);
    chk("mix_entry_spot", 64'(assigned_spot), 64'd5);
    chk("mix_full", 64'(full), 64'd1);
    repeat (G) step();

    do_exit(2, 8'hFB);
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    chk("pre_rst_grant", 64'(entry_grant), 64'd1);
    step();
    chk("pre_rst_gate", 64'(gate_open), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gate", 64'(gate_open), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_free", 64'(free_count), 64'd8);
    chk("arst_full", 64'(full), 64'd0);
    chk("arst_spot", 64'(assigned_spot), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    do_entry(0, 8'h01, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
